alu_seq_unit: RTL and testbench

//  Parametrised, registered successor to the 1-bit 4-function ALU cell.

---
 rtl/alu_seq_unit_if.sv | 32 +++
 rtl/alu_seq_unit.sv | 156 +++++++++++++++
 tb/tb_alu_seq_unit.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// alu_seq_unit_if
//   Handshake bundle for alu_seq_unit.
//   Upstream side : in_valid, in_ready, a, b, op
//   Downstream    : out_valid, out_ready, f, flag_z, flag_n, flag_c, flag_v
//   master : driven by the producer/consumer environment
//   slave  : the ALU itself
interface alu_seq_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, f, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, f, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq_unit.sv
// alu_seq_unit
//   Registered WIDTH-bit ALU: AND/OR/XOR/NOT/ADD/SUB in one cycle, logical
//   shifts serially at one bit per cycle. Valid/ready on both sides.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active-low
//   bus    : alu_seq_unit_if.slave (operands/opcode in, result/flags out)
//
//   state | meaning
//   IDLE  | ready for an operation (in_ready=1)
//   SHIFT | serial shift in progress, cnt = shifts still to do
//   DONE  | result and flags presented (out_valid=1) until out_ready
module alu_seq_unit #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst_n,
  alu_seq_unit_if.slave bus
);
  localparam int              CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM  = WIDTH'(WIDTH);
  localparam int              M       = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_reg;
  logic [CW-1:0]    cnt;
  logic             sh_right;
  logic [WIDTH-1:0] f_q;
  logic             z_q, n_q, c_q, v_q;

  logic             is_shift;
  logic [CW-1:0]    sh_cnt;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] imm_f;
  logic             imm_c, imm_v;
  logic [WIDTH-1:0] sh_next;
  logic             sh_out;
  logic             load_sh, shift_en, load_out;
  logic [WIDTH-1:0] out_f;
  logic             out_c, out_v;

  assign is_shift = (bus.op[2:1] == 2'b11);
  // Shift counts saturate at WIDTH: beyond that the result is already all zero.
  assign sh_cnt   = (bus.b >= W_LIM) ? CNT_MAX : bus.b[CW-1:0];
  assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff     = {1'b0, bus.a} - {1'b0, bus.b};
  assign sh_next  = sh_right ? {1'b0, sh_reg[WIDTH-1:1]} : {sh_reg[WIDTH-2:0], 1'b0};
  assign sh_out   = sh_right ? sh_reg[0] : sh_reg[M];

  // Single-cycle result; a shift by zero also lands here as a pass-through of a.
  always_comb begin
    imm_f = '0;
    imm_c = 1'b0;
    imm_v = 1'b0;
    case (bus.op)
      3'b000: imm_f = bus.a & bus.b;
      3'b001: imm_f = bus.a | bus.b;
      3'b010: imm_f = bus.a ^ bus.b;
      3'b011: imm_f = ~bus.a;
      3'b100: begin
        imm_f = sum[M:0];
        imm_c = sum[WIDTH];
        imm_v = (bus.a[M] == bus.b[M]) && (sum[M] != bus.a[M]);
      end
      3'b101: begin
        imm_f = diff[M:0];
        imm_c = ~diff[WIDTH];
        imm_v = (bus.a[M] != bus.b[M]) && (diff[M] != bus.a[M]);
      end
      default: imm_f = bus.a;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_sh   = 1'b0;
    shift_en  = 1'b0;
    load_out  = 1'b0;
    out_f     = imm_f;
    out_c     = imm_c;
    out_v     = imm_v;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          if (is_shift && (sh_cnt != '0)) begin
            load_sh   = 1'b1;
            state_nxt = SHIFT;
          end else begin
            load_out  = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        out_f    = sh_next;
        out_c    = sh_out;
        out_v    = 1'b0;
        if (cnt == CW'(1)) begin
          load_out  = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_reg   <= '0;
      cnt      <= '0;
      sh_right <= 1'b0;
      f_q      <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      if (load_sh) begin
        sh_reg   <= bus.a;
        cnt      <= sh_cnt;
        sh_right <= bus.op[0];
      end else if (shift_en) begin
        sh_reg <= sh_next;
        cnt    <= cnt - CW'(1);
      end
      // f/flags only change when a finished result is registered, so they
      // keep the previous result through IDLE and SHIFT.
      if (load_out) begin
        f_q <= out_f;
        z_q <= (out_f == '0);
        n_q <= out_f[M];
        c_q <= out_c;
        v_q <= out_v;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.f         = f_q;
  assign bus.flag_z    = z_q;
  assign bus.flag_n    = n_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit
//   Self-checking bench for alu_seq_unit (WIDTH=8): directed vector table,
//   randomized ops against an arithmetic reference model, backpressure and
//   mid-operation reset sequences.
module tb_alu_seq_unit;
  logic clk;
  logic rst_n;

  alu_seq_unit_if #(.WIDTH(8)) bus ();

  alu_seq_unit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] f;
    logic [3:0] flg;   // {z, n, c, v}
    int         lat;
  } res_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] f;
    logic [3:0] flg;
    int         lat;
  } vec_t;

  int passed = 0;
  int total  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act === exp_v) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
  endfunction

  function automatic res_t model(input logic [7:0] ma, input logic [7:0] mb, input logic [2:0] mop);
    res_t r;
    int   s, sa, sb, cnt;
    logic c, v;
    c     = 1'b0;
    v     = 1'b0;
    r.lat = 1;
    r.f   = 8'h00;
    sa    = int'($signed(ma));
    sb    = int'($signed(mb));
    cnt   = (int'(mb) > 8) ? 8 : int'(mb);
    case (mop)
      3'd0: r.f = ma & mb;
      3'd1: r.f = ma | mb;
      3'd2: r.f = ma ^ mb;
      3'd3: r.f = ~ma;
      3'd4: begin
        s   = int'(ma) + int'(mb);
        r.f = 8'(s);
        c   = (s > 255);
        v   = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      3'd5: begin
        s   = int'(ma) - int'(mb);
        r.f = 8'(s);
        c   = (ma >= mb);
        v   = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      3'd6: begin
        r.f   = 8'(int'(ma) << cnt);
        c     = (cnt == 0) ? 1'b0 : (((int'(ma) >> (8 - cnt)) & 1) != 0);
        r.lat = 1 + cnt;
      end
      default: begin
        r.f   = 8'(int'(ma) >> cnt);
        c     = (cnt == 0) ? 1'b0 : (((int'(ma) >> (cnt - 1)) & 1) != 0);
        r.lat = 1 + cnt;
      end
    endcase
    r.flg = {(r.f == 8'h00), r.f[7], c, v};
    return r;
  endfunction

  // Present one op, scramble inputs right after accept, wait for out_valid.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_, input logic [2:0] top, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.a        = ta;
    bus.b        = tb_;
    bus.op       = top;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a        = 8'($urandom);
    bus.b        = 8'($urandom);
    bus.op       = 3'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_check(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                           input logic [2:0] top, input res_t e);
    int lat;
    issue(ta, tb_, top, lat);
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_f"}, 32'(bus.f), 32'(e.f));
    chk({tag, "_flags"}, 32'({bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'(e.flg));
    @(posedge clk);
    #1;
    chk({tag, "_release"}, 32'({bus.out_valid, bus.in_ready}), 32'b01);
  endtask

  vec_t vecs[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    res_t e;
    int   lat, stale;
    logic [7:0] ra, rb;
    logic [2:0] rop;

    vecs[0]  = '{8'hFF, 8'h01, 3'd4, 8'h00, 4'b1010, 1};
    vecs[1]  = '{8'h80, 8'h01, 3'd5, 8'h7F, 4'b0011, 1};
    vecs[2]  = '{8'h01, 8'h02, 3'd5, 8'hFF, 4'b0100, 1};
    vecs[3]  = '{8'h81, 8'h03, 3'd6, 8'h08, 4'b0000, 4};
    vecs[4]  = '{8'h81, 8'h01, 3'd7, 8'h40, 4'b0010, 2};
    vecs[5]  = '{8'h5A, 8'h00, 3'd6, 8'h5A, 4'b0000, 1};
    vecs[6]  = '{8'h80, 8'hC8, 3'd7, 8'h00, 4'b1010, 9};
    vecs[7]  = '{8'hF0, 8'h3C, 3'd0, 8'h30, 4'b0000, 1};
    vecs[8]  = '{8'h00, 8'h00, 3'd1, 8'h00, 4'b1000, 1};
    vecs[9]  = '{8'hFF, 8'h0F, 3'd2, 8'hF0, 4'b0100, 1};
    vecs[10] = '{8'h55, 8'hFF, 3'd3, 8'hAA, 4'b0100, 1};
    vecs[11] = '{8'h7F, 8'h01, 3'd4, 8'h80, 4'b0101, 1};
    vecs[12] = '{8'h01, 8'h08, 3'd6, 8'h00, 4'b1010, 9};
    vecs[13] = '{8'h01, 8'h07, 3'd7, 8'h00, 4'b1000, 8};
    vecs[14] = '{8'h05, 8'h05, 3'd5, 8'h00, 4'b1010, 1};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.op        = 3'd0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", 32'({bus.out_valid, bus.f, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 15; i++) begin
      e.f   = vecs[i].f;
      e.flg = vecs[i].flg;
      e.lat = vecs[i].lat;
      run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op, e);
    end

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom);
      ra  = 8'($urandom);
      if (rop[2:1] == 2'b11 && $urandom_range(0, 3) != 0) rb = 8'($urandom_range(0, 9));
      else rb = 8'($urandom);
      run_check($sformatf("rnd%0d_op%0d_a%0h_b%0h", i, rop, ra, rb), ra, rb, rop, model(ra, rb, rop));
    end

    // Backpressure: result must hold while the consumer stalls.
    bus.out_ready = 1'b0;
    issue(8'h12, 8'h34, 3'd4, lat);
    chk("bp_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_f", 32'(bus.f), 32'h46);
      chk("bp_hold_ctl", 32'({bus.out_valid, bus.in_ready, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'b100000);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'({bus.out_valid, bus.in_ready}), 32'b01);

    // Reset in the middle of a 7-step shift.
    @(negedge clk);
    bus.a        = 8'hFF;
    bus.b        = 8'h07;
    bus.op       = 3'd6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("mid_rst_accepted", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'({bus.out_valid, bus.f, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    chk("mid_rst_no_stale", 32'(stale), 32'd0);
    run_check("post_rst", 8'h81, 8'h03, 3'd6, model(8'h81, 8'h03, 3'd6));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
